// File: rtl/gc_response_rx_if.sv
// Bundle between the GameCube response receiver and its host-side logic.
// The master drives the line sample and arm; the receiver (slave) reports results.
interface gc_response_rx_if #(
    parameter int unsigned NBITS = 64
);
    logic             data_in;
    logic             arm;
    logic             busy;
    logic             resp_valid;
    logic             resp_error;
    logic [NBITS-1:0] resp_data;
    logic [6:0]       bit_count;

    modport master (
        output data_in, arm,
        input  busy, resp_valid, resp_error, resp_data, bit_count
    );

    modport slave (
        input  data_in, arm,
        output busy, resp_valid, resp_error, resp_data, bit_count
    );
endinterface

// File: rtl/gc_response_rx.sv
// GameCube controller response receiver: decodes NBITS data bits plus stop bit
// from the released single-wire line, sampling each bit a fixed time after its falling edge.
module gc_response_rx #(
    parameter int unsigned SAMPLE_POINT  = 200,
    parameter int unsigned START_TIMEOUT = 10000,
    parameter int unsigned BIT_TIMEOUT   = 1000,
    parameter int unsigned LOW_MAX       = 500,
    parameter int unsigned NBITS         = 64
) (
    input logic            clk100mhz,
    input logic            reset,
    gc_response_rx_if.slave rx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FALL,
        ST_SAMPLE,
        ST_WAIT_RISE,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_POINT - 1);
    localparam logic [15:0] START_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] BIT_LAST    = 16'(BIT_TIMEOUT - 1);
    localparam logic [15:0] LOW_LAST    = 16'(LOW_MAX - 1);
    localparam logic [6:0]  NB_DATA     = 7'(NBITS);
    localparam logic [6:0]  NB_STOP     = 7'(NBITS + 1);

    state_e           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [6:0]       bit_count_q, bit_count_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] resp_data_q, resp_data_d;
    logic             busy_q, busy_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_error_q, resp_error_d;
    logic             sync1_q, s_q, s_prev_q;
    logic             fall;
    logic [15:0]      wait_limit;

    assign fall       = s_prev_q & ~s_q;
    assign wait_limit = (bit_count_q == '0) ? START_LAST : BIT_LAST;

    always_comb begin
        state_d      = state_q;
        bit_count_d  = bit_count_q;
        shreg_d      = shreg_q;
        resp_data_d  = resp_data_q;
        timer_d      = timer_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                // busy_q still covers the cycle right after DONE, so arm is refused there
                if (rx.arm && !busy_q) begin
                    state_d     = ST_WAIT_FALL;
                    bit_count_d = '0;
                    shreg_d     = '0;
                end
            end
            ST_WAIT_FALL: begin
                if (fall) begin
                    state_d = ST_SAMPLE;
                end else if (timer_q == wait_limit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SAMPLE: begin
                if (timer_q == SAMPLE_LAST) begin
                    bit_count_d = bit_count_q + 7'd1;
                    if (bit_count_q < NB_DATA) begin
                        shreg_d = {shreg_q[NBITS-2:0], s_q};
                    end
                    if (bit_count_q == NB_DATA && !s_q) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WAIT_RISE;
                    end
                end
            end
            ST_WAIT_RISE: begin
                if (s_q) begin
                    state_d = (bit_count_q == NB_STOP) ? ST_DONE : ST_WAIT_FALL;
                end else if (timer_q == LOW_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: begin
                resp_data_d = shreg_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Low-time budget runs from the falling edge, so SAMPLE->WAIT_RISE keeps counting
        if (state_d == ST_IDLE) begin
            timer_d = '0;
        end else if (state_d != state_q &&
                     !(state_q == ST_SAMPLE && state_d == ST_WAIT_RISE)) begin
            timer_d = '0;
        end

        resp_valid_d = (state_q == ST_DONE);
        resp_error_d = (state_d == ST_ERROR);
        busy_d       = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            s_q          <= 1'b1;
            s_prev_q     <= 1'b1;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_count_q  <= '0;
            shreg_q      <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            sync1_q      <= rx.data_in;
            s_q          <= sync1_q;
            s_prev_q     <= s_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_count_q  <= bit_count_d;
            shreg_q      <= shreg_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign rx.busy       = busy_q;
    assign rx.resp_valid = resp_valid_q;
    assign rx.resp_error = resp_error_q;
    assign rx.resp_data  = resp_data_q;
    assign rx.bit_count  = bit_count_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed bench for gc_response_rx: drives waveforms on data_in and checks
// decoded frames, pulse counts and cycle-exact timeouts against hand-derived values.
module tb_gc_response_rx;

    localparam int unsigned NB = 64;
    localparam logic [63:0] D1 = 64'hA5A5_0F0F_8080_1234;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk100mhz = 1'b0;
    logic reset = 1'b1;

    gc_response_rx_if #(.NBITS(NB)) bus ();

    gc_response_rx #(
        .SAMPLE_POINT (200),
        .START_TIMEOUT(10000),
        .BIT_TIMEOUT  (1000),
        .LOW_MAX      (500),
        .NBITS        (NB)
    ) dut (
        .clk100mhz(clk100mhz),
        .reset    (reset),
        .rx       (bus)
    );

    always #5 clk100mhz = ~clk100mhz;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_fall_cyc = 0;
    int last_rise_cyc = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int v0, e0, arm_cyc;

    always @(posedge clk100mhz) cyc++;

    always @(negedge clk100mhz) begin
        if (bus.resp_valid === 1'b1) valid_cnt++;
        if (bus.resp_error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; low for lo cycles, then high for hi cycles.
    task automatic send_bit(input logic b, input int lo, input int hi, input logic pulse_arm);
        bus.data_in = 1'b0;
        last_fall_cyc = cyc;
        bus.arm = pulse_arm;
        @(negedge clk100mhz);
        bus.arm = 1'b0;
        repeat (lo - 1) @(negedge clk100mhz);
        bus.data_in = 1'b1;
        last_rise_cyc = cyc;
        repeat (hi) @(negedge clk100mhz);
    endtask

    task automatic send_bits(input logic [63:0] d, input int n, input int lo1, input int hi1,
                             input int lo0, input int hi0, input int arm_idx);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = d[63-i];
            send_bit(b, b ? lo1 : lo0, b ? hi1 : hi0, i == arm_idx);
        end
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        @(negedge clk100mhz);
        bus.arm = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.busy !== 1'b0; i++) @(negedge clk100mhz);
        repeat (3) @(negedge clk100mhz);
    endtask

    task automatic wait_err(input int budget);
        for (int i = 0; i < budget && err_cnt == e0; i++) @(negedge clk100mhz);
    endtask

    initial begin
        bus.data_in = 1'b1;
        bus.arm = 1'b0;
        reset = 1'b1;

        // 1: reset (with a colliding arm), reset state, arm -> busy next cycle
        @(negedge clk100mhz);
        bus.arm = 1'b1;
        @(negedge clk100mhz);
        bus.arm = 1'b0;
        @(negedge clk100mhz);
        reset = 1'b0;
        @(negedge clk100mhz);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_error", 64'(bus.resp_error), 64'd0);
        check("rst_data", bus.resp_data, 64'd0);
        check("rst_bitcnt", 64'(bus.bit_count), 64'd0);
        arm_pulse();
        check("arm_busy", 64'(bus.busy), 64'd1);

        // 2: nominal 1us/3us lows, 4us period
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(D1, 64, 100, 300, 300, 100, -1);
        send_bit(1'b1, 100, 300, 1'b0);
        wait_idle();
        check("t2_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("t2_err_cnt", 64'(err_cnt - e0), 64'd0);
        check("t2_data", bus.resp_data, D1);
        check("t2_bitcnt", 64'(bus.bit_count), 64'd65);
        check("t2_busy", 64'(bus.busy), 64'd0);

        // 3: skewed lows 1.8us / 2.2us
        arm_pulse();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(D1, 64, 180, 30, 220, 10, -1);
        send_bit(1'b1, 180, 30, 1'b0);
        wait_idle();
        check("t3_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("t3_err_cnt", 64'(err_cnt - e0), 64'd0);
        check("t3_data", bus.resp_data, D1);

        // 4: line stays high -> start timeout
        arm_cyc = cyc;
        arm_pulse();
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_err(12000);
        check("t4_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("t4_err_delay", 64'(err_cyc - arm_cyc), 64'd10001);
        wait_idle();
        check("t4_valid_cnt", 64'(valid_cnt - v0), 64'd0);
        check("t4_data_kept", bus.resp_data, D1);

        // 5a: frame stops after 20 bits (last bit is a '0') -> bit timeout
        arm_pulse();
        e0 = err_cnt;
        send_bits(D1, 20, 100, 110, 300, 10, -1);
        wait_err(2000);
        check("t5a_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("t5a_err_delay", 64'(err_cyc - last_rise_cyc), 64'd1003);
        check("t5a_bitcnt", 64'(bus.bit_count), 64'd20);
        wait_idle();

        // 5b: bit 5 held low 6us -> low-time limit
        arm_pulse();
        e0 = err_cnt;
        send_bits(64'hB000_0000_0000_0000, 5, 100, 110, 300, 10, -1);
        send_bit(1'b0, 600, 50, 1'b0);
        wait_idle();
        check("t5b_err_cnt", 64'(err_cnt - e0), 64'd1);
        check("t5b_err_delay", 64'(err_cyc - last_fall_cyc), 64'd503);
        check("t5b_bitcnt", 64'(bus.bit_count), 64'd6);
        check("t5b_data_kept", bus.resp_data, D1);

        // 6: reset at bit 30, then full all-ones frame with an ignored mid-frame arm
        arm_pulse();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(D1, 30, 100, 110, 300, 10, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk100mhz);
        reset = 1'b0;
        @(negedge clk100mhz);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        check("t6_rst_data", bus.resp_data, 64'd0);
        check("t6_rst_bitcnt", 64'(bus.bit_count), 64'd0);
        check("t6_rst_pulses", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
        arm_pulse();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(ONES, 64, 100, 110, 300, 10, 10);
        send_bit(1'b1, 100, 110, 1'b0);
        wait_idle();
        check("t6_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("t6_err_cnt", 64'(err_cnt - e0), 64'd0);
        check("t6_data", bus.resp_data, ONES);
        check("t6_bitcnt", 64'(bus.bit_count), 64'd65);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gc_response_rx.md
# gc_response_rx

Receiver for the GameCube controller single-wire response. It decodes the 64-bit frame plus stop bit that the controller drives after the host query/poll command has been transmitted and the host has released the line. It runs directly on the 100 MHz clock with no divided clock. It sits beside the query transmitter: the transmitter drives the open-drain line and then releases it, and this block samples the released line and presents the decoded controller state to the rest of the design.

## Interface
Parameters:
- SAMPLE_POINT, 200: cycles after a synchronized falling edge at which the bit value is sampled (2 µs).
- START_TIMEOUT, 10000: maximum number of cycles from `arm` to the falling edge of bit 0.
- BIT_TIMEOUT, 1000: maximum number of cycles from a rising edge to the next falling edge.
- LOW_MAX, 500: maximum number of cycles, measured from the falling edge, that the line may stay low within one bit.
- NBITS, 64: number of data bits in the frame, excluding the stop bit.

Ports:
- clk100mhz  in  1  100 MHz clock. It is the only clock in the block.
- reset  in  1  Synchronous, active-high reset.
- data_in  in  1  Raw line level, read from the tristated inout pad.
- arm  in  1  One-cycle pulse that starts a reception. It is ignored while `busy`=1.
- busy  out  1  High from the cycle after an accepted `arm` until the cycle in which `resp_valid` or `resp_error` pulses, inclusive.
- resp_valid  out  1  One-cycle pulse that marks a good frame.
- resp_error  out  1  One-cycle pulse that marks a failed frame.
- resp_data  out  NBITS  Last good frame. The first received bit is in [NBITS-1].
- bit_count  out  7  Number of bits sampled so far in the current frame, including the stop bit.

## Operation
- `data_in` passes through a 2-flop synchronizer to produce `s`, with `s_prev` as the previous value.
  - Falling edge = `s_prev`=1 and `s`=0.
  - Rising edge = `s`=1.
  - Both flops and `s_prev` reset to 1.
- One 16-bit `timer` serves all states. It clears on every state transition and otherwise increments each cycle.

State machine:
- **IDLE**
  - `busy`=0.
  - `arm` → WAIT_FALL, with `bit_count`=0 and the shift register cleared.
- **WAIT_FALL**
  - Falling edge → SAMPLE.
  - If no falling edge arrives, go to ERROR when `timer` = limit−1. The limit is START_TIMEOUT when `bit_count`=0 and BIT_TIMEOUT otherwise.
  - A line that is already low at `arm` does not count as an edge. A high→low transition is required.
- **SAMPLE**
  - When `timer`=SAMPLE_POINT−1:
    - Sample `s`.
    - `bit_count`+1.
    - If `bit_count` < NBITS, shift the sample into the LSB of the shift register.
    - Go to WAIT_RISE.
  - If the sample is the stop bit (the sample with index NBITS) and it reads 0, go to ERROR instead.
- **WAIT_RISE**
  - `timer` continues from the falling edge and does not clear on entry from SAMPLE.
  - `s`=1 with `bit_count`=NBITS+1 → DONE.
  - `s`=1 with `bit_count` < NBITS+1 → WAIT_FALL.
  - `timer`=LOW_MAX−1 while `s`=0 → ERROR.
- **DONE**
  - `resp_data` ← shift register.
  - `resp_valid`=1 for this cycle.
  - → IDLE.
- **ERROR**
  - `resp_error`=1 for this cycle.
  - `resp_data` is unchanged.
  - → IDLE.

Other rules:
- Bit decode: a '1' is 1 µs low and a '0' is 3 µs low. Sampling at 2 µs gives ±0.9 µs tolerance.
- Reset at any time, including mid-frame:
  - State goes to IDLE.
  - `resp_data`=0, `bit_count`=0, and `busy`, `resp_valid` and `resp_error` go to 0.
  - Any partial frame is discarded.
- `arm` in the same cycle as `reset`: reset wins.
- `arm` while busy, or in the DONE or ERROR cycle: ignored, not queued.
- `arm` must be issued only after the host transmitter has finished its stop bit and released the line.

## Timing
- Reset values: `busy`=0, `resp_valid`=0, `resp_error`=0, `resp_data`=0, `bit_count`=0.
- `arm` at cycle N gives `busy`=1 at cycle N+1.
- Input latency is 2 cycles of synchronizer delay, applied equally to every edge.
- The sample instant is SAMPLE_POINT cycles after the synchronized falling edge.
- `resp_valid` and the updated `resp_data` appear together, 2 cycles after the synchronized stop-bit rise is seen in WAIT_RISE (WAIT_RISE→DONE, then registered outputs).
- `busy` drops in the cycle after the `resp_valid` or `resp_error` pulse.
- The earliest next accepted `arm` is in the cycle `busy`=0.
- Timeouts are exact to the cycle: `resp_error` is asserted on the cycle after `timer` reaches limit−1.

## Test plan
1. Reset held 3 cycles with `data_in`=1 → all outputs 0 and `busy`=0. Then `arm` → `busy`=1 at the next cycle.
2. Arm, then drive 64'hA5A5_0F0F_8080_1234 MSB-first plus a stop '1', using 1 µs/3 µs low and a 4 µs bit period → one `resp_valid` pulse, `resp_data`=64'hA5A5_0F0F_8080_1234, `bit_count`=65, and `resp_error` never asserted.
3. Same frame with the low times skewed to 1.8 µs for '1' and 2.2 µs for '0' → data decoded identically. A second frame of all-ones → `resp_data`=64'hFFFF_FFFF_FFFF_FFFF.
4. Arm with the line held high → `resp_error` exactly 10001 cycles after `arm` and `resp_data` keeps its previous value.
5. Frame stopped after 20 bits → `resp_error` BIT_TIMEOUT cycles after the last synchronized rise. Line held low 6 µs in bit 5 → `resp_error` at LOW_MAX.
6. Assert `reset` at bit 30 → IDLE and `resp_data`=0. Then arm and send a full frame → correct `resp_data`. A second `arm` pulsed mid-frame is ignored, and there is exactly one `resp_valid`.
